dz_count_ctrl: RTL and testbench
================================

# dz_count_ctrl

Countdown sequencer for the 8x8 dot-matrix digit display. It runs from the 1 kHz display clock and owns the `num` code consumed by the row-scanning display block. It counts from a preset value down to 0 at one step per second, with start, pause and clear controls. It reports completion and can blink the final digit.

## Interface
Parameters:
- `TICK_DIV`, default 1000: clk cycles per count step (1 kHz → 1 Hz). Legal range ≥ 2, even.
- `START_VAL`, default 5: reload value. Legal range 0..5, the digits the display can draw.

Ports:
- `clk`  in  1: 1 kHz clock, shared with the display block.
- `rst`  in  1: reset, asynchronous, active-high.
- `start_p`  in  1: single-cycle pulse, already debounced. Starts or restarts the count.
- `pause_p`  in  1: single-cycle pulse. Toggles RUN ↔ PAUSE.
- `clr_p`  in  1: single-cycle pulse. Aborts to IDLE.
- `num`  out  3: digit code driven to the display. 3'd7 = blank, which the display renders as all-off.
- `running`  out  1: high in RUN only.
- `done`  out  1: one-cycle pulse when the count reaches 0.

## Operation
- **Architecture:** single clock, one FSM plus a prescaler. All outputs are registered.
- **States:** IDLE, RUN, PAUSE, DONE.
- **Prescaler `pre`:**
  - Width `$clog2(TICK_DIV)`.
  - Counts only in RUN. Wraps from TICK_DIV-1 to 0.
  - A tick occurs on the edge where `pre == TICK_DIV-1` in RUN.
  - Holds its value in PAUSE, so a resumed second continues where it stopped.
  - Cleared to 0 on every start and on clr.
- **Input priority in one cycle:** `clr_p` > `start_p` > `pause_p`.
- **IDLE:**
  - `num` = START_VAL.
  - `start_p` → RUN, `pre` ← 0. If START_VAL = 0, `start_p` → DONE instead, with `done` pulsed.
  - `pause_p` ignored.
- **RUN:**
  - On a tick, `num` ← `num`-1.
  - If the new `num` is 0: → DONE and `done` ← 1 on the same edge.
  - `pause_p` → PAUSE.
  - `start_p` → reload `num` = START_VAL, `pre` ← 0, stay in RUN.
- **PAUSE:**
  - `num` and `pre` frozen.
  - `pause_p` → RUN.
  - `start_p` → reload and RUN.
- **DONE:**
  - `num` = 0 (see Configuration for blink).
  - `start_p` → reload and RUN.
  - `pause_p` ignored.
- **`clr_p` in any state:** → IDLE, `num` = START_VAL, `pre` = 0, `done` = 0.
- **Tick and `pause_p` in the same cycle:** the decrement is applied, then the state is PAUSE. If the decrement reaches 0, DONE wins and the pause is dropped.
- **`num` range:** never leaves 0..START_VAL except for the blank code 7. No wrap below 0.

## Timing
- **Reset values:** state IDLE, `num` = START_VAL, `running` = 0, `done` = 0, `pre` = 0, blink phase 0.
- **`rst` mid-operation:** forces reset values immediately (asynchronous). The first action is possible on the first edge after `rst` deasserts.
- **Start latency:** `start_p` sampled at edge k → `running` = 1 after edge k.
- **First decrement:** visible after edge k+TICK_DIV.
- **Uninterrupted count:** `done` is high for exactly the cycle after edge k+START_VAL·TICK_DIV. `num` shows 0 from that same edge.
- **Pause:** each PAUSE interval of P cycles delays every later event by exactly P cycles.
- **`done` pulse:** never longer than 1 cycle. It is not re-asserted while the block remains in DONE.

## Configuration
- **Macro `DZ_CTRL_BLINK_EN` defined:**
  - In DONE, `num` alternates 0 / 7 every TICK_DIV/2 cycles.
  - The blink starts with 0 on DONE entry and continues until the block leaves DONE.
  - Uses a separate half-period counter, which is reset on DONE entry.
- **Macro undefined:**
  - `num` holds 0 in DONE.
  - No blink counter is built.

## Test plan
All scenarios use TICK_DIV = 4 and START_VAL = 5.
- **Reset:** pulse `rst` mid-RUN with `num` = 3 → `num` = 5, `running` = 0, `done` = 0 immediately. The next `start_p` gives the first decrement 4 edges later.
- **Full count:** `start_p` at edge 0 → `num` goes 4, 3, 2, 1, 0 after edges 4, 8, 12, 16, 20. `done` is high only in the cycle after edge 20. `running` is 0 after edge 20.
- **Pause mid-second:** `start_p` at edge 0, `pause_p` at edge 6, `pause_p` at edge 16 → `num` = 4 held from edge 6 to 16, next decrement after edge 18, `done` after edge 30.
- **Priority:**
  - `clr_p` and `start_p` at the same edge during RUN → IDLE, `num` = 5, `running` = 0.
  - `start_p` at edge 10 during RUN → `num` = 5, next decrement after edge 14.
- **Done restart:** `start_p` while in DONE → `num` = 5, `running` = 1 next cycle, with no second `done` until the new count completes.
- **Blink:**
  - With `DZ_CTRL_BLINK_EN`, in DONE `num` reads 0, 0, 7, 7, 0, 0, … per cycle.
  - Without the macro, `num` stays 0 for at least 20 cycles.

Source files
------------

// File: rtl/dz_count_if.sv
// dz_count_if: control/display bundle for the countdown sequencer.
//   start_p, pause_p, clr_p : single-cycle command pulses into the sequencer
//   num                     : 3-bit digit code to the display (3'd7 = blank)
//   running                 : high while counting
//   done                    : one-cycle pulse when the count reaches 0
// master = command source (e.g. button front end), slave = dz_count_ctrl.
interface dz_count_if;
    logic       start_p;
    logic       pause_p;
    logic       clr_p;
    logic [2:0] num;
    logic       running;
    logic       done;

    modport master (output start_p, pause_p, clr_p, input num, running, done);
    modport slave  (input start_p, pause_p, clr_p, output num, running, done);
endinterface

// File: rtl/dz_count_ctrl.sv
// dz_count_ctrl: countdown sequencer for the 8x8 dot-matrix digit display.
// Counts from START_VAL down to 0, one step every TICK_DIV clocks, with
// start / pause / clear pulse controls (priority clr > start > pause).
// Ports:
//   clk  : 1 kHz display clock
//   rst  : asynchronous active-high reset
//   bus  : dz_count_if.slave (start_p, pause_p, clr_p in; num, running, done out)
// Optional feature: define DZ_CTRL_BLINK_EN to blink the final 0 digit
// (0 / blank alternating every TICK_DIV/2 cycles while in DONE).
module dz_count_ctrl #(
    parameter int TICK_DIV  = 1000,
    parameter int START_VAL = 5
) (
    input  logic       clk,
    input  logic       rst,
    dz_count_if.slave  bus
);

    localparam int         PW         = $clog2(TICK_DIV);
    localparam logic [2:0] SV         = 3'(START_VAL);
    localparam bit         ZERO_START = (START_VAL == 0);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state_q, state_n;
    logic [PW-1:0] pre_q, pre_n;
    logic [2:0]    cnt_q, cnt_n;
    logic [2:0]    num_q, num_n;
    logic          running_q;
    logic          done_q, done_n;

    // Next-state / datapath
    always_comb begin
        state_n = state_q;
        pre_n   = pre_q;
        cnt_n   = cnt_q;
        done_n  = 1'b0;
        if (bus.clr_p) begin
            state_n = IDLE;
            cnt_n   = SV;
            pre_n   = '0;
        end else if (bus.start_p) begin
            cnt_n = SV;
            pre_n = '0;
            // A zero preset has nothing to count: finish immediately, but do
            // not re-pulse done if we are already sitting in DONE.
            if (ZERO_START) begin
                state_n = DONE;
                done_n  = (state_q != DONE);
            end else begin
                state_n = RUN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (pre_q == PW'(TICK_DIV - 1)) begin
                        pre_n = '0;
                        cnt_n = cnt_q - 3'd1;
                        // Reaching 0 takes precedence over a coincident pause.
                        if (cnt_n == 3'd0) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end else if (bus.pause_p) begin
                            state_n = PAUSE;
                        end
                    end else begin
                        pre_n = pre_q + 1'b1;
                        if (bus.pause_p) state_n = PAUSE;
                    end
                end
                PAUSE: if (bus.pause_p) state_n = RUN;
                default: ;
            endcase
        end
    end

`ifdef DZ_CTRL_BLINK_EN
    localparam int HALF = TICK_DIV / 2;
    localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [HW-1:0] half_q, half_n;
    logic          phase_q, phase_n;

    // Half-period counter restarts on DONE entry so the blink always opens
    // with a full half-period of 0.
    always_comb begin
        half_n  = '0;
        phase_n = 1'b0;
        if (state_q == DONE && state_n == DONE) begin
            if (half_q == HW'(HALF - 1)) begin
                phase_n = ~phase_q;
            end else begin
                half_n  = half_q + 1'b1;
                phase_n = phase_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            half_q  <= half_n;
            phase_q <= phase_n;
        end
    end

    assign num_n = (state_n == DONE && phase_n) ? 3'd7 : cnt_n;
`else
    assign num_n = cnt_n;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            cnt_q     <= SV;
            num_q     <= SV;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            pre_q     <= pre_n;
            cnt_q     <= cnt_n;
            num_q     <= num_n;
            running_q <= (state_n == RUN);
            done_q    <= done_n;
        end
    end

    assign bus.num     = num_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_dz_count_ctrl.sv
// Testbench for dz_count_ctrl with TICK_DIV = 4, START_VAL = 5.
// Expected {num, running, done} values are pushed to a scoreboard queue as
// each cycle's stimulus is driven and popped/compared once the edge is done.
module tb_dz_count_ctrl;

    localparam int TD   = 4;
    localparam int SVAL = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dz_count_if bus();

    dz_count_ctrl #(.TICK_DIV(TD), .START_VAL(SVAL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [4:0] sb[$];
    logic [4:0] exp_v, obs_v;

    function automatic logic [4:0] pack(int n, bit r, bit d);
        return {3'(n), r, d};
    endfunction

    // Digit shown during the countdown after c counted edges
    function automatic int cnt_num(int c);
        return SVAL - c / TD;
    endfunction

    // Digit shown d edges after DONE entry
    function automatic int done_num(int d);
`ifdef DZ_CTRL_BLINK_EN
        return (((d / (TD / 2)) % 2) != 0) ? 7 : 0;
`else
        return (d >= 0) ? 0 : 0;
`endif
    endfunction

    // Drive one cycle of pulses; starts and ends at a negedge.
    task automatic step(bit s, bit p, bit c);
        bus.start_p = s;
        bus.pause_p = p;
        bus.clr_p   = c;
        @(posedge clk);
        @(negedge clk);
        bus.start_p = 1'b0;
        bus.pause_p = 1'b0;
        bus.clr_p   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_p = 1'b0;
        bus.pause_p = 1'b0;
        bus.clr_p   = 1'b0;
        @(negedge clk);
        sb.push_back(pack(SVAL, 0, 0));
        obs_v = {bus.num, bus.running, bus.done}; exp_v = sb.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL reset_por got %b want %b", obs_v, exp_v); end
        rst = 1'b0;
        // Count down to num = 3 (after edge 8)
        for (int e = 0; e <= 8; e++) begin
            sb.push_back(pack(cnt_num(e), 1, 0));
            step(e == 0, 0, 0);
            obs_v = {bus.num, bus.running, bus.done}; exp_v = sb.pop_front(); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL reset_run e=%0d got %b want %b", e, obs_v, exp_v); end
        end
        // Asynchronous reset takes effect without a clock edge
        #2 rst = 1'b1;
        #1;
        sb.push_back(pack(SVAL, 0, 0));
        obs_v = {bus.num, bus.running, bus.done}; exp_v = sb.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL reset_async got %b want %b", obs_v, exp_v); end
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e <= 5; e++) begin
            sb.push_back(pack(cnt_num(e), 1, 0));
            step(e == 0, 0, 0);
            obs_v = {bus.num, bus.running, bus.done}; exp_v = sb.pop_front(); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL reset_restart e=%0d got %b want %b", e, obs_v, exp_v); end
        end
        sb.push_back(pack(SVAL, 0, 0));
        step(0, 0, 1);
        obs_v = {bus.num, bus.running, bus.done}; exp_v = sb.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL reset_clr got %b want %b", obs_v, exp_v); end
    endtask

    // Uninterrupted count, start at edge 0, 24 cycles observed in DONE
    task automatic test_full_count(string tag);
        for (int e = 0; e <= 44; e++) begin
            if (e < 20) sb.push_back(pack(cnt_num(e), 1, 0));
            else        sb.push_back(pack(done_num(e - 20), 0, e == 20));
            step(e == 0, 0, 0);
            obs_v = {bus.num, bus.running, bus.done}; exp_v = sb.pop_front(); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL %s e=%0d got %b want %b", tag, e, obs_v, exp_v); end
        end
    endtask

    task automatic test_done_restart();
        test_full_count("done_restart");
    endtask

    // Pause at edge 6, resume at edge 16: 10-cycle delay of later events
    task automatic test_pause();
        sb.push_back(pack(SVAL, 0, 0));
        step(0, 0, 1);
        obs_v = {bus.num, bus.running, bus.done}; exp_v = sb.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL clr_in_done got %b want %b", obs_v, exp_v); end
        for (int e = 0; e <= 34; e++) begin
            int c;
            c = (e <= 6) ? e : (e <= 16) ? 6 : e - 10;
            if (c < 20) sb.push_back(pack(cnt_num(c), (e < 6) || (e >= 16), 0));
            else        sb.push_back(pack(done_num(e - 30), 0, e == 30));
            step(e == 0, e == 6 || e == 16, 0);
            obs_v = {bus.num, bus.running, bus.done}; exp_v = sb.pop_front(); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL pause e=%0d got %b want %b", e, obs_v, exp_v); end
        end
    endtask

    // Restart at edge 10, then clr+start together at edge 16, pause in IDLE
    task automatic test_priority();
        sb.push_back(pack(SVAL, 0, 0));
        step(0, 0, 1);
        obs_v = {bus.num, bus.running, bus.done}; exp_v = sb.pop_front(); checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL prio_clr got %b want %b", obs_v, exp_v); end
        for (int e = 0; e <= 18; e++) begin
            if (e < 10)      sb.push_back(pack(cnt_num(e), 1, 0));
            else if (e < 16) sb.push_back(pack(cnt_num(e - 10), 1, 0));
            else             sb.push_back(pack(SVAL, 0, 0));
            step(e == 0 || e == 10 || e == 16, e == 17, e == 16);
            obs_v = {bus.num, bus.running, bus.done}; exp_v = sb.pop_front(); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL priority e=%0d got %b want %b", e, obs_v, exp_v); end
        end
    endtask

    // Pause coinciding with a tick, and with the final tick (DONE wins)
    task automatic test_tick_pause();
        for (int e = 0; e <= 26; e++) begin
            int c;
            c = (e <= 4) ? e : (e <= 8) ? 4 : e - 4;
            if (c < 20) sb.push_back(pack(cnt_num(c), (e < 4) || (e >= 8), 0));
            else        sb.push_back(pack(done_num(e - 24), 0, e == 24));
            step(e == 0, e == 4 || e == 8 || e == 24 || e == 25, 0);
            obs_v = {bus.num, bus.running, bus.done}; exp_v = sb.pop_front(); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL tick_pause e=%0d got %b want %b", e, obs_v, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_full_count("full_count");
        test_done_restart();
        test_pause();
        test_priority();
        test_tick_pause();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
